// File: rtl/modexp_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : modexp_stream_ctrl_if
//  Purpose  : Host streams, status and ModExp-side signals of modexp_stream_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
interface modexp_stream_ctrl_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  start;
    logic [DATA_WIDTH-1:0] nprime0_in;
    logic [DATA_WIDTH-1:0] in_m, in_e, in_n, in_r, in_t;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [DATA_WIDTH-1:0] m_buf, e_buf, n_buf, r_buf, t_buf, nprime0;
    logic                  startInput;
    logic                  startCompute;
    logic                  getResult;
    logic [4:0]            exp_state;
    logic [DATA_WIDTH-1:0] res_out;

    // slave: the controller; master: the host and ModExp surrounding it
    modport slave (
        input  start, nprime0_in, in_m, in_e, in_n, in_r, in_t, in_valid, out_ready,
               exp_state, res_out,
        output in_ready, out_data, out_valid, out_last, busy, done, err,
               m_buf, e_buf, n_buf, r_buf, t_buf, nprime0,
               startInput, startCompute, getResult
    );
    modport master (
        output start, nprime0_in, in_m, in_e, in_n, in_r, in_t, in_valid, out_ready,
               exp_state, res_out,
        input  in_ready, out_data, out_valid, out_last, busy, done, err,
               m_buf, e_buf, n_buf, r_buf, t_buf, nprime0,
               startInput, startCompute, getResult
    );
endinterface
`default_nettype wire

// File: rtl/modexp_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : modexp_stream_ctrl
//  Purpose  : Word-serial operand loader and result FIFO/streamer around ModExp.
//             Optional compute watchdog enabled by defining MODEXP_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module modexp_stream_ctrl #(
    parameter int DATA_WIDTH     = 64,
    parameter int WORDS          = 64,
    parameter int COMPLETE_STATE = 9,
    parameter int TIMEOUT        = 2**24
) (
    input  wire logic            clk,
    input  wire logic            reset,
    modexp_stream_ctrl_if.slave  bus
);
    localparam int IW = $clog2(WORDS + 1);
    localparam int PW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] C_IDX_END   = IW'(WORDS);
    localparam logic [IW-1:0] C_LAST_WORD = IW'(WORDS - 1);
    localparam logic [PW-1:0] C_PTR_LAST  = PW'(WORDS - 1);
    localparam logic [4:0]    C_COMPLETE  = 5'(COMPLETE_STATE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_READ    = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_idx, w_idx_nxt;
    logic            r_err, w_err_nxt;
    logic            r_done, w_done_nxt;
    logic            w_accept, w_take, w_push;

    logic [DATA_WIDTH-1:0] r_mem [WORDS];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [IW-1:0]         r_cnt, r_ocnt;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid, r_out_last;
    logic                  w_pop, w_oload, w_from_mem, w_bypass, w_wr;
    logic [DATA_WIDTH-1:0] r_m, r_e, r_n, r_r, r_t, r_np0;

`ifdef MODEXP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] r_tmo;
    logic          w_tmo_hit;

    assign w_tmo_hit = (r_tmo == C_TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                   r_tmo <= '0;
        else if (r_state == S_COMPUTE) r_tmo <= r_tmo + 1'b1;
        else                          r_tmo <= '0;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err_nxt   = r_err;
        w_done_nxt  = 1'b0;
        w_accept    = 1'b0;
        w_take      = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (r_idx == C_IDX_END) begin
                    w_state_nxt = S_COMPUTE;
                end else if (bus.in_valid) begin
                    w_take    = 1'b1;
                    w_idx_nxt = r_idx + 1'b1;
                end else begin
                    // A starved load would leave ModExp with a torn operand
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_COMPUTE: begin
                if (bus.exp_state == C_COMPLETE) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_READ;
                end
`ifdef MODEXP_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`endif
            end
            S_READ: begin
                // Index 0 carries a stale res_out sample and is dropped
                w_push = (r_idx != '0);
                if (r_idx == C_IDX_END) w_state_nxt = S_DRAIN;
                else                    w_idx_nxt   = r_idx + 1'b1;
            end
            S_DRAIN: begin
                if (w_pop && r_out_last) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_err   <= w_err_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {r_m, r_e, r_n, r_r, r_t, r_np0} <= '0;
        end else begin
            if (w_accept) r_np0 <= bus.nprime0_in;
            if (w_take) begin
                r_m <= bus.in_m;
                r_e <= bus.in_e;
                r_n <= bus.in_n;
                r_r <= bus.in_r;
                r_t <= bus.in_t;
            end
        end
    end

    // Output register acts as the FIFO head; an empty FIFO forwards res_out straight into it
    assign w_pop      = r_out_valid & bus.out_ready;
    assign w_oload    = ~r_out_valid | w_pop;
    assign w_from_mem = w_oload & (r_cnt != '0);
    assign w_bypass   = w_oload & (r_cnt == '0) & w_push;
    assign w_wr       = w_push & ~w_bypass;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= bus.res_out;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_ocnt      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_wr)       r_wr_ptr <= (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_from_mem) r_rd_ptr <= (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            case ({w_wr, w_from_mem})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_oload) begin
                r_out_valid <= w_from_mem | w_bypass;
                r_out_last  <= 1'b0;
                if (w_from_mem | w_bypass) begin
                    r_out_data <= w_from_mem ? r_mem[r_rd_ptr] : bus.res_out;
                    r_out_last <= (r_ocnt == C_LAST_WORD);
                    r_ocnt     <= r_ocnt + 1'b1;
                end
            end
            if (w_accept) r_ocnt <= '0;
        end
    end

    assign bus.in_ready     = (r_state == S_LOAD) && (r_idx != C_IDX_END);
    assign bus.startInput   = (r_state == S_LOAD) || (r_state == S_COMPUTE) || (r_state == S_READ);
    assign bus.startCompute = ((r_state == S_LOAD) && (r_idx == C_IDX_END)) ||
                              (r_state == S_COMPUTE) || (r_state == S_READ);
    assign bus.getResult    = bus.startCompute;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.out_data     = r_out_data;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_last     = r_out_last;
    assign bus.m_buf        = r_m;
    assign bus.e_buf        = r_e;
    assign bus.n_buf        = r_n;
    assign bus.r_buf        = r_r;
    assign bus.t_buf        = r_t;
    assign bus.nprime0      = r_np0;
endmodule
`default_nettype wire

// File: tb/tb_modexp_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_modexp_stream_ctrl
//  Purpose  : Directed bench; plays host and ModExp around modexp_stream_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_modexp_stream_ctrl;
    localparam int DW  = 64;
    localparam int W   = 64;
    localparam int TMO = 100;
    localparam logic [DW-1:0] NP0 = 64'h1234_5678_9ABC_DEF1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    modexp_stream_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    modexp_stream_ctrl #(
        .DATA_WIDTH(DW), .WORDS(W), .COMPLETE_STATE(9), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int sc_cnt = 0;
    int rdy_mode = 0;
    int cyc = 0;
    logic [DW-1:0] got_q [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
        if (bus.done) done_cnt++;
        if (bus.startCompute) sc_cnt++;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    endtask

    function automatic logic [DW-1:0] wv(input int mode, input int k);
        if (mode == 0) return (k == 0) ? 64'd50 : 64'd0;
        return 64'(1000 + 7 * k);
    endfunction

    task automatic do_start();
        bus.start      = 1'b1;
        bus.nprime0_in = NP0;
        tick();
        bus.start      = 1'b0;
    endtask

    // m=8, e=13, n=77 in word 0, upper words zero
    task automatic load_words(input int lo, input int hi);
        for (int k = lo; k < hi; k++) begin
            bus.in_m     = (k == 0) ? 64'd8  : 64'd0;
            bus.in_e     = (k == 0) ? 64'd13 : 64'd0;
            bus.in_n     = (k == 0) ? 64'd77 : 64'd0;
            bus.in_r     = (k == 0) ? 64'd23 : 64'd0;
            bus.in_t     = (k == 0) ? 64'd36 : 64'd0;
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    // Signals completion at cycle C and plays the res_out sequence of READ
    task automatic stream(input int mode, input bit inline_chk);
        bus.exp_state = 5'd9;
        tick();
        bus.exp_state = 5'd0;
        bus.res_out   = 64'hBAD;
        if (inline_chk) chk("read_c1_valid", bus.out_valid, 0);
        tick();
        if (inline_chk) chk("read_c2_valid", bus.out_valid, 0);
        for (int k = 0; k < W; k++) begin
            bus.res_out = wv(mode, k);
            tick();
            if (inline_chk) begin
                chk("pp_valid", bus.out_valid, 1);
                chk("pp_data", bus.out_data, wv(mode, k));
                chk("pp_last", bus.out_last, (k == W - 1) ? 1 : 0);
            end
        end
        bus.res_out = 64'hBAD;
    endtask

    task automatic run_load_compute();
        do_start();
        load_words(0, W);
        tick();
        repeat (3) tick();
    endtask

    initial begin
        bus.start = 0; bus.nprime0_in = 0; bus.in_valid = 0;
        bus.in_m = 0; bus.in_e = 0; bus.in_n = 0; bus.in_r = 0; bus.in_t = 0;
        bus.out_ready = 1; bus.exp_state = 0; bus.res_out = 0;

        // Reset state
        tick(); tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_ctrl", {bus.startInput, bus.startCompute, bus.getResult, bus.done, bus.err}, 0);
        reset = 1'b1;
        tick();

        // Reset mid-LOAD at word 20
        do_start();
        load_words(0, 20);
        chk("mid_busy_pre", bus.busy, 1);
        reset = 1'b0;
        #1;
        chk("mid_busy", bus.busy, 0);
        chk("mid_ctrl", {bus.startInput, bus.startCompute, bus.getResult, bus.in_ready}, 0);
        chk("mid_bufs", bus.m_buf | bus.e_buf | bus.nprime0, 0);
        chk("mid_flags", {bus.done, bus.err, bus.out_valid}, 0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Full job with gapless load and out_ready held high
        got_q.delete(); done_cnt = 0;
        do_start();
        chk("s1_startInput", bus.startInput, 1);
        chk("s1_in_ready", bus.in_ready, 1);
        chk("s1_nprime0", bus.nprime0, NP0);
        load_words(0, 1);
        chk("ld_m", bus.m_buf, 8);
        chk("ld_n", bus.n_buf, 77);
        chk("ld_sc_low", bus.startCompute, 0);
        load_words(1, W);
        chk("ld_sc_high", bus.startCompute, 1);
        chk("ld_gr_high", bus.getResult, 1);
        tick();
        repeat (3) tick();
        chk("cmp_busy", bus.busy, 1);
        stream(0, 1'b1);
        chk("drain_ctrl", {bus.startInput, bus.startCompute}, 0);
        tick();
        chk("done_pulse", bus.done, 1);
        chk("done_idle", bus.busy, 0);
        tick();
        chk("done_low", bus.done, 0);
        chk("full_count", got_q.size(), W);
        chk("full_w0", (got_q.size() > 0) ? got_q[0] : 64'hX, 50);
        chk("full_done_cnt", done_cnt, 1);

        // Simultaneous push/pop with distinct words
        run_load_compute();
        stream(1, 1'b1);
        tick(); tick();

        // Backpressure, start pulsed during DRAIN
        got_q.delete(); done_cnt = 0; rdy_mode = 1;
        run_load_compute();
        stream(1, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("bp_drain_busy", bus.busy, 1);
        for (int i = 0; i < 400 && !bus.done; i++) tick();
        chk("bp_done", bus.done, 1);
        tick();
        repeat (3) tick();
        chk("bp_restart_ignored", {bus.busy, bus.startInput}, 0);
        chk("bp_count", got_q.size(), W);
        for (int k = 0; k < got_q.size(); k++) chk("bp_word", got_q[k], wv(1, k));
        chk("bp_done_cnt", done_cnt, 1);
        rdy_mode = 0;

        // Load gap at word 10
        got_q.delete(); sc_cnt = 0;
        do_start();
        load_words(0, 10);
        tick();
        chk("gap_err", bus.err, 1);
        chk("gap_idle", {bus.busy, bus.startInput, bus.in_ready}, 0);
        repeat (4) tick();
        chk("gap_err_sticky", bus.err, 1);
        chk("gap_no_compute", sc_cnt, 0);
        chk("gap_no_output", got_q.size(), 0);

        // Compute watchdog
        do_start();
        chk("to_err_cleared", bus.err, 0);
        load_words(0, W);
        tick();
        chk("to_entry_sc", bus.startCompute, 1);
`ifdef MODEXP_TIMEOUT_EN
        repeat (TMO - 1) tick();
        chk("to_pre_err", bus.err, 0);
        chk("to_pre_busy", bus.busy, 1);
        tick();
        chk("to_err", bus.err, 1);
        chk("to_idle", {bus.busy, bus.startCompute}, 0);
`else
        repeat (2 * TMO) tick();
        chk("nto_busy", bus.busy, 1);
        chk("nto_err", bus.err, 0);
        chk("nto_sc", bus.startCompute, 1);
        reset = 1'b0;
        #1;
        chk("nto_abort", bus.busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
